masked_sbox_layer_pipe: RTL and testbench
=========================================

// Module: masked_sbox_layer_pipe
// PURPOSE
//  Registered, parallel 5-share threshold-implementation PRINCE S-box layer: NUM_SBOX nibbles per beat.
//  Selects forward S or inverse S^-1 per beat. Registers after the component functions stop glitch propagation.
//  Valid/ready elastic pipeline of PIPE_STAGES registers. Sits between key/round-constant addition and the
//  masked M-layer of the round-based masked PRINCE core.
// PARAMETERS
//  NUM_SBOX      16  S-boxes in parallel; each share bus is 4*NUM_SBOX bits wide
//  PIPE_STAGES   1   output register stages, legal values 1 or 2
//  CLEAR_ON_IDLE 1   1: zero a stage's share registers when it empties (no stale shares are left held)
// PORTS
//  clk        in   1           clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  in_valid   in   1           input beat valid
//  in_ready   out  1           layer accepts a beat this cycle
//  inv        in   1           0: S, 1: S^-1; sampled with the beat
//  v,w,x,y,z  in   4*NUM_SBOX  input shares; nibble i belongs to S-box i
//  out_valid  out  1           output beat valid
//  out_ready  in   1           downstream accepts
//  z_v..z_z   out  4*NUM_SBOX  output shares; XOR of the 5 shares = S(/S^-1)(XOR of the input shares)
//  busy       out  1           any stage holds valid data
// BEHAVIOUR
//  - Reset (async assert, sync deassert is external): all valid flags 0; all share registers 0;
//    in_ready = 1 after reset; out_valid = 0; busy = 0.
//  - Stage 1 input: per-nibble combinational 5-share component functions. Output share j never uses input share j
//    (non-completeness). Per share, a mux picks the forward or inverse result. The mux is driven by inv only;
//    it never mixes two share domains.
//  - Stage k register loads when valid_{k-1} && ready_k. ready_k = !valid_k || ready_{k+1}.
//    ready_{last+1} = out_ready. in_ready = ready_1. This is purely combinational on valid and ready: no bubble.
//  - Latency: PIPE_STAGES cycles from acceptance to out_valid with out_ready held high. Throughput: 1 beat/cycle.
//  - Backpressure: while out_valid && !out_ready, z_* and out_valid hold stable; upstream stages fill, then in_ready = 0.
//  - Simultaneous drain and fill of the same stage: the new beat is loaded and the valid flag stays 1.
//    The clear does not apply in that cycle.
//  - CLEAR_ON_IDLE = 1: a stage that drains with no incoming beat writes all 5 share registers to 0 in that cycle.
//    CLEAR_ON_IDLE = 0: the stage holds its data and only the valid flag drops.
//  - in_valid = 0: inputs (including inv) are don't-care, and no register changes except a clear.
//  - Reset mid-operation: in-flight beats are discarded. No output beat appears until a new beat is accepted.
//  - PIPE_STAGES outside {1,2}: elaboration error.
//  - Shares are assumed to be a uniform 5-share sharing. The block adds no fresh randomness.
//    The TI component functions are uniform, so no remask is needed.
// STRUCTURE
//  - Shared package prince_ti_pkg:
//    constants SHARES = 5, NIBBLE = 4;
//    functions prince_sbox and prince_sbox_inv, used only by the bench model:
//    S = B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4.
//  - Sub-module masked_sbox_slice, combinational, one nibble:
//    forward and inverse 5-share component functions plus the per-share inv mux.
//    It is generated NUM_SBOX times.
//  - Top level: the generate loop, the PIPE_STAGES register/valid chain, and the clear logic.
// TESTING
//  1 Reset: drive rst_n = 0 mid-cycle -> out_valid = 0, z_* = 0, in_ready = 1 immediately (async).
//  2 Forward: inv = 0, v = 0, w = x = y = z = 0, PIPE_STAGES = 1 -> after 1 cycle out_valid = 1;
//    XOR of the output shares = 0xBBBB_BBBB_BBBB_BBBB.
//    Repeat with random sharings of 0x0123_4567_89AB_CDEF -> 0xBF32_AC91_6780_E5D4.
//  3 Inverse: inv = 1, sharing of 0xBF32_AC91_6780_E5D4 -> XOR of the output shares = 0x0123_4567_89AB_CDEF.
//    Also alternate inv on back-to-back beats -> each beat uses its own mode.
//  4 Backpressure, PIPE_STAGES = 2: stream 5 beats with out_ready = 0 -> in_ready falls after 2 accepts.
//    z_* stay stable. Release -> beats emerge in order, one per cycle, none lost or duplicated.
//  5 Clear: CLEAR_ON_IDLE = 1, one beat drained with in_valid = 0 -> next cycle all z_* = 0, busy = 0.
//    CLEAR_ON_IDLE = 0 -> z_* hold the values.
//  6 Reset mid-stream: assert rst_n low while 2 beats are in flight -> both discarded.
//    After release, out_valid stays 0 until a new accept.

Source files
------------

// File: rtl/prince_ti_pkg.sv
// Shared constants for the 5-share threshold PRINCE S-box layer, plus the
// unmasked reference S-box functions.
package prince_ti_pkg;

  localparam int unsigned SHARES = 5;
  localparam int unsigned NIBBLE = 4;

  typedef logic [SHARES-1:0][NIBBLE-1:0] nib_shares_t;

  function automatic logic [3:0] prince_sbox(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h0: r = 4'hB;  4'h1: r = 4'hF;  4'h2: r = 4'h3;  4'h3: r = 4'h2;
      4'h4: r = 4'hA;  4'h5: r = 4'hC;  4'h6: r = 4'h9;  4'h7: r = 4'h1;
      4'h8: r = 4'h6;  4'h9: r = 4'h7;  4'hA: r = 4'h8;  4'hB: r = 4'h0;
      4'hC: r = 4'hE;  4'hD: r = 4'h5;  4'hE: r = 4'hD;  4'hF: r = 4'h4;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] prince_sbox_inv(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h0: r = 4'hB;  4'h1: r = 4'h7;  4'h2: r = 4'h3;  4'h3: r = 4'h2;
      4'h4: r = 4'hF;  4'h5: r = 4'hD;  4'h6: r = 4'h8;  4'h7: r = 4'h9;
      4'h8: r = 4'hA;  4'h9: r = 4'h6;  4'hA: r = 4'h4;  4'hB: r = 4'h0;
      4'hC: r = 4'h5;  4'hD: r = 4'hE;  4'hE: r = 4'hC;  4'hF: r = 4'h1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/masked_sbox_slice.sv
// One nibble of the 5-share PRINCE S-box layer: forward and inverse
// component functions followed by a per-share mode mux.
module masked_sbox_slice
  import prince_ti_pkg::*;
(
  input  logic                          inv,
  input  logic [SHARES-1:0][NIBBLE-1:0] sh_i,
  output logic [SHARES-1:0][NIBBLE-1:0] sh_o
);

  localparam logic [15:0][3:0] S_FWD = 64'h4D5E_0876_19CA_23FB;
  localparam logic [15:0][3:0] S_INV = 64'h1CE5_046A_98DF_237B;

  // Degree-3 map over 5 shares: S(sum) = sum of S over all share triples plus
  // S of every single share. Share j takes the two triples that omit j and
  // the single share j-1, so it never sees input share j.
  for (genvar j = 0; j < SHARES; j++) begin : g_share
    localparam logic [2:0] J1 = 3'((j + 1) % SHARES);
    localparam logic [2:0] J2 = 3'((j + 2) % SHARES);
    localparam logic [2:0] J3 = 3'((j + 3) % SHARES);
    localparam logic [2:0] J4 = 3'((j + 4) % SHARES);

    logic [NIBBLE-1:0] tri_a, tri_b, single;
    logic [NIBBLE-1:0] fwd, bwd;

    assign tri_a  = sh_i[J2] ^ sh_i[J3] ^ sh_i[J4];
    assign tri_b  = sh_i[J1] ^ sh_i[J3] ^ sh_i[J4];
    assign single = sh_i[J4];

    assign fwd = S_FWD[tri_a] ^ S_FWD[tri_b] ^ S_FWD[single];
    assign bwd = S_INV[tri_a] ^ S_INV[tri_b] ^ S_INV[single];

    assign sh_o[j] = inv ? bwd : fwd;
  end

endmodule

// File: rtl/masked_sbox_layer_pipe.sv
// Registered 5-share PRINCE S-box layer with a valid/ready elastic pipeline
// of PIPE_STAGES register stages.
module masked_sbox_layer_pipe
  import prince_ti_pkg::*;
#(
  parameter int unsigned NUM_SBOX      = 16,
  parameter int unsigned PIPE_STAGES   = 1,
  parameter bit          CLEAR_ON_IDLE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       inv,
  input  logic [NIBBLE*NUM_SBOX-1:0] v,
  input  logic [NIBBLE*NUM_SBOX-1:0] w,
  input  logic [NIBBLE*NUM_SBOX-1:0] x,
  input  logic [NIBBLE*NUM_SBOX-1:0] y,
  input  logic [NIBBLE*NUM_SBOX-1:0] z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NIBBLE*NUM_SBOX-1:0] z_v,
  output logic [NIBBLE*NUM_SBOX-1:0] z_w,
  output logic [NIBBLE*NUM_SBOX-1:0] z_x,
  output logic [NIBBLE*NUM_SBOX-1:0] z_y,
  output logic [NIBBLE*NUM_SBOX-1:0] z_z,
  output logic                       busy
);

  localparam int unsigned W    = NIBBLE * NUM_SBOX;
  localparam int unsigned LAST = PIPE_STAGES - 1;

  typedef logic [SHARES-1:0][W-1:0] stage_t;

  if ((PIPE_STAGES < 1) || (PIPE_STAGES > 2)) begin : g_bad_cfg
    $error("masked_sbox_layer_pipe: PIPE_STAGES must be 1 or 2");
  end

  stage_t sh_in;
  stage_t sh_out;

  assign sh_in = {z, y, x, w, v};

  // Per-nibble component functions; share index 0..4 maps to v..z.
  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_sbox
    nib_shares_t nib_in;
    nib_shares_t nib_out;

    for (genvar j = 0; j < SHARES; j++) begin : g_map
      assign nib_in[j]                     = sh_in[j][i*NIBBLE +: NIBBLE];
      assign sh_out[j][i*NIBBLE +: NIBBLE] = nib_out[j];
    end

    masked_sbox_slice u_slice (
      .inv  (inv),
      .sh_i (nib_in),
      .sh_o (nib_out)
    );
  end

  stage_t [PIPE_STAGES-1:0] data_q, data_d;
  logic   [PIPE_STAGES-1:0] valid_q, valid_d;
  logic   [PIPE_STAGES:0]   ready_c;

  assign ready_c[PIPE_STAGES] = out_ready;

  // A stage can take a beat unless it and every stage after it is full and stalled.
  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    logic   feed;
    logic   load;
    logic   drain;
    stage_t src;

    if (k == 0) begin : g_head
      assign feed = in_valid;
      assign src  = sh_out;
    end else begin : g_tail
      assign feed = valid_q[k-1];
      assign src  = data_q[k-1];
    end

    assign ready_c[k] = out_ready || !(&valid_q[LAST:k]);
    assign load       = feed && ready_c[k];
    assign drain      = valid_q[k] && ready_c[k+1];

    // A refill wins over the idle clear.
    always_comb begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
      if (load) begin
        valid_d[k] = 1'b1;
        data_d[k]  = src;
      end else if (drain) begin
        valid_d[k] = 1'b0;
        if (CLEAR_ON_IDLE) begin
          data_d[k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready                  = ready_c[0];
  assign out_valid                 = valid_q[LAST];
  assign {z_z, z_y, z_x, z_w, z_v} = data_q[LAST];
  assign busy                      = |valid_q;

endmodule

// File: tb/tb_masked_sbox_layer_pipe.sv
// Scoreboard bench for masked_sbox_layer_pipe: one single-stage instance with
// idle clearing and one two-stage instance that holds data when idle.
module tb_masked_sbox_layer_pipe;
  import prince_ti_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv_a, iv_b, inv, or_a, or_b;
  logic [63:0] v, w, x, y, z;

  logic        in_ready_a, out_valid_a, busy_a;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [63:0] z_v_a, z_w_a, z_x_a, z_y_a, z_z_a;
  logic [63:0] z_v_b, z_w_b, z_x_b, z_y_b, z_z_b;
  logic [63:0] xor_a, xor_b, or_sh_a;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] q_a [$];
  logic [63:0] q_b [$];

  always #5 clk = ~clk;

  masked_sbox_layer_pipe #(.NUM_SBOX(16), .PIPE_STAGES(1), .CLEAR_ON_IDLE(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(in_ready_a), .inv(inv),
    .v(v), .w(w), .x(x), .y(y), .z(z),
    .out_valid(out_valid_a), .out_ready(or_a),
    .z_v(z_v_a), .z_w(z_w_a), .z_x(z_x_a), .z_y(z_y_a), .z_z(z_z_a), .busy(busy_a)
  );

  masked_sbox_layer_pipe #(.NUM_SBOX(16), .PIPE_STAGES(2), .CLEAR_ON_IDLE(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(in_ready_b), .inv(inv),
    .v(v), .w(w), .x(x), .y(y), .z(z),
    .out_valid(out_valid_b), .out_ready(or_b),
    .z_v(z_v_b), .z_w(z_w_b), .z_x(z_x_b), .z_y(z_y_b), .z_z(z_z_b), .busy(busy_b)
  );

  assign xor_a   = z_v_a ^ z_w_a ^ z_x_a ^ z_y_a ^ z_z_a;
  assign xor_b   = z_v_b ^ z_w_b ^ z_x_b ^ z_y_b ^ z_z_b;
  assign or_sh_a = z_v_a | z_w_a | z_x_a | z_y_a | z_z_a;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic md, input logic [63:0] s);
    logic [63:0] r;
    for (int i = 0; i < 16; i++)
      r[i*4 +: 4] = md ? prince_sbox_inv(s[i*4 +: 4]) : prince_sbox(s[i*4 +: 4]);
    return r;
  endfunction

  task automatic set_shares(input logic [63:0] secret, input bit rnd);
    if (rnd) begin
      w = {$urandom, $urandom};
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      z = {$urandom, $urandom};
    end else begin
      w = '0; x = '0; y = '0; z = '0;
    end
    v = secret ^ w ^ x ^ y ^ z;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one beat and returns 1 ns after the edge that accepted it.
  task automatic drive_beat(input bit sel_b, input bit md, input logic [63:0] secret, input bit rnd);
    bit acc;
    acc = 1'b0;
    set_shares(secret, rnd);
    inv = md;
    if (sel_b) iv_b = 1'b1;
    else       iv_a = 1'b1;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = sel_b ? in_ready_b : in_ready_a;
      @(posedge clk);
      #1;
    end
    iv_a = 1'b0;
    iv_b = 1'b0;
    check_eq(sel_b ? "b_accept" : "a_accept", 64'(acc), 64'd1);
  endtask

  // Scoreboard: push the model result on accept, pop and compare on output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (iv_a && in_ready_a) q_a.push_back(model(inv, v ^ w ^ x ^ y ^ z));
      if (iv_b && in_ready_b) q_b.push_back(model(inv, v ^ w ^ x ^ y ^ z));
      if (out_valid_a && or_a) begin
        check_eq("a_expected_beat", 64'(q_a.size() != 0), 64'd1);
        if (q_a.size() != 0) check_eq("a_beat", xor_a, q_a.pop_front());
      end
      if (out_valid_b && or_b) begin
        check_eq("b_expected_beat", 64'(q_b.size() != 0), 64'd1);
        if (q_b.size() != 0) check_eq("b_beat", xor_b, q_b.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] snap [5];
    bit acc;
    int n_acc;

    rst_n = 1'b0; iv_a = 1'b0; iv_b = 1'b0; inv = 1'b0; or_a = 1'b1; or_b = 1'b1;
    set_shares(64'd0, 1'b0);
    run_cycles(2);
    check_eq("rst_a_out_valid", 64'(out_valid_a), 64'd0);
    check_eq("rst_a_in_ready",  64'(in_ready_a),  64'd1);
    check_eq("rst_a_shares",    or_sh_a,          64'd0);
    check_eq("rst_b_busy",      64'(busy_b),      64'd0);
    check_eq("rst_b_shares",    z_v_b | z_w_b | z_x_b | z_y_b | z_z_b, 64'd0);
    rst_n = 1'b1;
    run_cycles(1);

    // Forward mode, single stage
    drive_beat(1'b0, 1'b0, 64'd0, 1'b0);
    check_eq("a_latency", 64'(out_valid_a), 64'd1);
    check_eq("a_fwd_zero", xor_a, 64'hBBBB_BBBB_BBBB_BBBB);
    for (int i = 0; i < 3; i++) begin
      drive_beat(1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1);
      check_eq("a_fwd_kat", xor_a, 64'hBF32_AC91_6780_E5D4);
    end

    // Inverse mode and alternating modes on back-to-back beats
    drive_beat(1'b0, 1'b1, 64'hBF32_AC91_6780_E5D4, 1'b1);
    check_eq("a_inv_kat", xor_a, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 8; i++) drive_beat(1'b0, 1'(i), {$urandom, $urandom}, 1'b1);

    // Idle clear on the single-stage instance
    run_cycles(1);
    check_eq("a_clear_shares", or_sh_a, 64'd0);
    check_eq("a_clear_busy", 64'(busy_a), 64'd0);
    check_eq("a_clear_valid", 64'(out_valid_a), 64'd0);

    for (int i = 0; i < 6; i++) drive_beat(1'b1, 1'(i), {$urandom, $urandom}, 1'b1);
    run_cycles(3);

    // Backpressure on the two-stage instance
    or_b = 1'b0;
    n_acc = 0;
    set_shares({$urandom, $urandom}, 1'b1);
    inv = 1'b0;
    iv_b = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_ready_b;
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        set_shares({$urandom, $urandom}, 1'b1);
        inv = ~inv;
      end
    end
    iv_b = 1'b0;
    check_eq("b_fill_accepts", 64'(n_acc), 64'd2);
    check_eq("b_stall_in_ready", 64'(in_ready_b), 64'd0);
    check_eq("b_stall_out_valid", 64'(out_valid_b), 64'd1);
    snap[0] = z_v_b; snap[1] = z_w_b; snap[2] = z_x_b; snap[3] = z_y_b; snap[4] = z_z_b;
    run_cycles(3);
    check_eq("b_hold_v", z_v_b, snap[0]);
    check_eq("b_hold_w", z_w_b, snap[1]);
    check_eq("b_hold_x", z_x_b, snap[2]);
    check_eq("b_hold_y", z_y_b, snap[3]);
    check_eq("b_hold_z", z_z_b, snap[4]);
    check_eq("b_hold_valid", 64'(out_valid_b), 64'd1);
    or_b = 1'b1;
    for (int i = 0; i < 3; i++) drive_beat(1'b1, 1'(i), {$urandom, $urandom}, 1'b1);
    run_cycles(4);
    check_eq("b_drained", 64'(q_b.size()), 64'd0);

    // Two-stage latency and hold-on-idle with clearing disabled
    drive_beat(1'b1, 1'b0, {$urandom, $urandom}, 1'b1);
    check_eq("b_latency_pre", 64'(out_valid_b), 64'd0);
    run_cycles(1);
    check_eq("b_latency", 64'(out_valid_b), 64'd1);
    snap[0] = z_v_b; snap[1] = z_w_b; snap[4] = z_z_b;
    run_cycles(1);
    check_eq("b_idle_valid", 64'(out_valid_b), 64'd0);
    check_eq("b_idle_busy", 64'(busy_b), 64'd0);
    check_eq("b_idle_hold_v", z_v_b, snap[0]);
    check_eq("b_idle_hold_w", z_w_b, snap[1]);
    check_eq("b_idle_hold_z", z_z_b, snap[4]);

    // Asynchronous reset mid-cycle with a stalled beat
    or_a = 1'b0;
    drive_beat(1'b0, 1'b0, {$urandom, $urandom}, 1'b1);
    check_eq("a_stalled_valid", 64'(out_valid_a), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_a_out_valid", 64'(out_valid_a), 64'd0);
    check_eq("arst_a_in_ready", 64'(in_ready_a), 64'd1);
    check_eq("arst_a_shares", or_sh_a, 64'd0);
    check_eq("arst_a_busy", 64'(busy_a), 64'd0);
    q_a.delete();
    q_b.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    or_a = 1'b1;
    run_cycles(1);

    // Reset with two beats in flight
    or_b = 1'b0;
    drive_beat(1'b1, 1'b0, {$urandom, $urandom}, 1'b1);
    drive_beat(1'b1, 1'b1, {$urandom, $urandom}, 1'b1);
    check_eq("b_inflight_busy", 64'(busy_b), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("b_rst_out_valid", 64'(out_valid_b), 64'd0);
    check_eq("b_rst_busy", 64'(busy_b), 64'd0);
    q_b.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    or_b = 1'b1;
    for (int c = 0; c < 4; c++) begin
      run_cycles(1);
      check_eq("b_post_rst_quiet", 64'(out_valid_b), 64'd0);
    end
    drive_beat(1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1);
    check_eq("b_new_pre", 64'(out_valid_b), 64'd0);
    run_cycles(1);
    check_eq("b_new_valid", 64'(out_valid_b), 64'd1);
    check_eq("b_new_kat", xor_b, 64'hBF32_AC91_6780_E5D4);

    run_cycles(4);
    check_eq("a_queue_empty", 64'(q_a.size()), 64'd0);
    check_eq("b_queue_empty", 64'(q_b.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
